seqdet_arbiter: RTL and testbench

Shares one bit-serial "101" pattern detector between NREQ requesters. Grants the detector to one requester at a time, round-robin. Streams exactly FRAME_LEN valid bits from the winner through the embedded Mealy detection logic, counts matches, and returns the count over a valid/ack result handshake. Sits between the serial-link front ends and the status/statistics logic.

---
 rtl/seqdet_arbiter_if.sv | 24 ++
 rtl/seqdet_arbiter.sv | 110 +++++++++++
 tb/tb_seqdet_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/seqdet_arbiter_if.sv
// seqdet_arbiter_if: request/serial-data/result bundle between the requester front ends and seqdet_arbiter.
interface seqdet_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int CNT_W = 5
);
   localparam int ID_W = $clog2(NREQ);
   logic [NREQ-1:0]  req;
   logic [NREQ-1:0]  bit_in;
   logic [NREQ-1:0]  bit_vld;
   logic [NREQ-1:0]  gnt;
   logic             res_vld;
   logic [ID_W-1:0]  res_id;
   logic [CNT_W-1:0] res_cnt;
   logic             res_abort;
   logic             res_ack;
   modport master (
      output req, bit_in, bit_vld, res_ack,
      input  gnt, res_vld, res_id, res_cnt, res_abort
   );
   modport slave (
      input  req, bit_in, bit_vld, res_ack,
      output gnt, res_vld, res_id, res_cnt, res_abort
   );
endinterface

// File: rtl/seqdet_arbiter.sv
// seqdet_arbiter: round-robin share of one Mealy "101" detector across NREQ serial lanes.
// Define SEQDET_OVERLAP_EN for overlapping detection; the default build is non-overlapping.
module seqdet_arbiter #(
   parameter int NREQ      = 4,
   parameter int FRAME_LEN = 16,
   parameter int CNT_W     = 5
) (
   input logic             clk_i,
   input logic             rst_ni,
   seqdet_arbiter_if.slave bus
);
   localparam int ID_W = $clog2(NREQ);
   localparam int BC_W = $clog2(FRAME_LEN);
   typedef enum logic [1:0] {IDLE, STREAM, REPORT} state_e;
   typedef enum logic [1:0] {S0, S1, S2} det_e;
`ifdef SEQDET_OVERLAP_EN
   localparam det_e DET_HIT = S1;
`else
   localparam det_e DET_HIT = S0;
`endif
   state_e           state_q, state_d;
   det_e             det_q, det_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [ID_W-1:0]  owner_q, owner_d, rr_ptr_q, rr_ptr_d, win;
   logic [BC_W-1:0]  bcnt_q, bcnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             abort_q, abort_d, found, v, b, rq, last, hit;
   logic [ID_W:0]    idx;
   // descending scan so the lowest offset from rr_ptr is the last to win
   always_comb begin
      win = '0;
      found = 1'b0;
      idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = {1'b0, rr_ptr_q} + (ID_W + 1)'(i);
         idx = (idx >= (ID_W + 1)'(NREQ)) ? idx - (ID_W + 1)'(NREQ) : idx;
         if (bus.req[idx[ID_W-1:0]]) begin
            win = idx[ID_W-1:0];
            found = 1'b1;
         end
      end
   end
   assign v    = bus.bit_vld[owner_q];
   assign b    = bus.bit_in[owner_q];
   assign rq   = bus.req[owner_q];
   assign last = bcnt_q == BC_W'(FRAME_LEN - 1);
   assign hit  = det_q == S2 && b;
   always_comb begin
      state_d  = state_q;
      det_d    = det_q;
      gnt_d    = gnt_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      bcnt_d   = bcnt_q;
      cnt_d    = cnt_q;
      abort_d  = abort_q;
      case (state_q)
         IDLE: if (found) begin
            state_d  = STREAM;
            gnt_d    = NREQ'(1) << win;
            owner_d  = win;
            rr_ptr_d = (win == ID_W'(NREQ - 1)) ? '0 : win + 1'b1;
            bcnt_d   = '0;
            cnt_d    = '0;
            det_d    = S0;
            abort_d  = 1'b0;
         end
         // a final valid bit takes priority over a simultaneous req drop
         STREAM: if (v && (last || rq)) begin
            bcnt_d  = bcnt_q + 1'b1;
            cnt_d   = cnt_q + CNT_W'(hit && cnt_q != '1);
            det_d   = b ? (det_q == S2 ? DET_HIT : S1) : (det_q == S1 ? S2 : S0);
            state_d = last ? REPORT : STREAM;
            gnt_d   = last ? '0 : gnt_q;
         end else if (!rq) begin
            state_d = REPORT;
            gnt_d   = '0;
            abort_d = 1'b1;
         end
         REPORT: state_d = bus.res_ack ? IDLE : REPORT;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         det_q    <= S0;
         gnt_q    <= '0;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         bcnt_q   <= '0;
         cnt_q    <= '0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         det_q    <= det_d;
         gnt_q    <= gnt_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         bcnt_q   <= bcnt_d;
         cnt_q    <= cnt_d;
         abort_q  <= abort_d;
      end
   end
   assign bus.gnt       = gnt_q;
   assign bus.res_vld   = state_q == REPORT;
   assign bus.res_id    = owner_q;
   assign bus.res_cnt   = cnt_q;
   assign bus.res_abort = abort_q;
endmodule

// File: tb/tb_seqdet_arbiter.sv
// tb_seqdet_arbiter: frames scored against a string-level "101" match model and a round-robin pick model.
module tb_seqdet_arbiter;
   localparam int NREQ = 4, FRAME_LEN = 16, CNT_W = 5;
   localparam int ID_W = $clog2(NREQ);
`ifdef SEQDET_OVERLAP_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif
   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [CNT_W-1:0] cnt;
      logic             abort;
   } res_t;
   logic clk = 1'b0, rst_n = 1'b0;
   int   n_tests = 0, n_fail = 0, ptr = 0;
   bit   mon_en = 1'b1;
   res_t exp_q[$];
   seqdet_arbiter_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();
   seqdet_arbiter #(.NREQ(NREQ), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // leftmost-first pattern search; a non-overlapping match may not reuse the previous trailing 1
   function automatic int count_101(input logic [FRAME_LEN-1:0] fb, input int n);
      int c = 0, next_ok = 0;
      for (int i = 0; i + 2 < n; i++)
         if (i >= next_ok && fb[i] && !fb[i+1] && fb[i+2]) begin
            c++;
            next_ok = OVL ? i + 2 : i + 3;
         end
      return (c > 2**CNT_W - 1) ? 2**CNT_W - 1 : c;
   endfunction
   function automatic int pick(input logic [NREQ-1:0] m, input int p);
      for (int i = 0; i < NREQ; i++)
         if (m[(p + i) % NREQ]) return (p + i) % NREQ;
      return 0;
   endfunction
   task automatic check_zero(input string tag);
      check({tag, "_gnt"}, bus.gnt, 0);
      check({tag, "_res_vld"}, bus.res_vld, 0);
      check({tag, "_res_id"}, bus.res_id, 0);
      check({tag, "_res_cnt"}, bus.res_cnt, 0);
      check({tag, "_res_abort"}, bus.res_abort, 0);
   endtask
   task automatic wait_gnt();
      int guard = 0;
      while (bus.gnt == '0 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
   endtask
   task automatic run_frame(input logic [NREQ-1:0] mask, input logic [FRAME_LEN-1:0] fb,
                            input int vmode, input int abort_at, input bit drop_last, input bit push);
      int   w, k, guard, gnt_bad;
      logic v;
      bit   done;
      res_t e;
      w = pick(mask, ptr);
      ptr = (w + 1) % NREQ;
      e.id = ID_W'(w);
      e.cnt = CNT_W'(count_101(fb, abort_at >= 0 ? abort_at : FRAME_LEN));
      e.abort = abort_at >= 0;
      if (push) exp_q.push_back(e);
      @(negedge clk);
      bus.req = mask;
      bus.bit_vld = '0;
      wait_gnt();
      check("grant_onehot", bus.gnt, NREQ'(1) << w);
      k = 0; guard = 0; gnt_bad = 0; done = 1'b0;
      while (!done && guard < 20 * FRAME_LEN) begin
         guard++;
         bus.bit_in = NREQ'($urandom);
         bus.bit_vld = NREQ'($urandom);
         v = 1'b0;
         if (abort_at == k) begin
            bus.req[w] = 1'b0;
            bus.bit_vld[w] = (k < FRAME_LEN - 1) ? 1'($urandom) : 1'b0;
         end else begin
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? guard[0] : ($urandom_range(0, 3) != 0);
            if (drop_last && k == FRAME_LEN - 1) begin
               v = 1'b1;
               bus.req[w] = 1'b0;
            end
            bus.bit_vld[w] = v;
            bus.bit_in[w] = fb[k];
         end
         @(posedge clk);
         done = (abort_at == k) || (v && k == FRAME_LEN - 1);
         if (v) k++;
         @(negedge clk);
         if (!done && bus.gnt !== (NREQ'(1) << w)) gnt_bad++;
      end
      bus.bit_vld = '0;
      check("stream_done", done, 1);
      check("gnt_held", gnt_bad, 0);
      check("end_gnt_low", bus.gnt, 0);
      check("end_res_vld", bus.res_vld, 1);
   endtask
   initial begin
      res_t e;
      bit   have;
      bus.res_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n && bus.res_vld === 1'b1) begin
            bus.res_ack = 1'b0;
            have = exp_q.size() != 0;
            if (!have) check("unexpected_result", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("res_id", bus.res_id, e.id);
               check("res_cnt", bus.res_cnt, e.cnt);
               check("res_abort", bus.res_abort, e.abort);
            end
            repeat ($urandom_range(0, 3)) begin
               @(negedge clk);
               if (have) check("res_hold", {bus.res_vld, bus.res_id, bus.res_cnt, bus.res_abort},
                               {1'b1, e.id, e.cnt, e.abort});
            end
            bus.res_ack = 1'b1;
            @(negedge clk);
            bus.res_ack = 1'b0;
            check("ack_clears", bus.res_vld, 0);
         end else bus.res_ack = !bus.res_vld && ($urandom_range(0, 7) == 0);
      end
   end
   initial begin
      int hold_bad, guard, ab;
      bus.req = '0; bus.bit_in = '0; bus.bit_vld = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) run_frame('1, '0, 0, -1, 1'b0, 1'b1);
      run_frame(4'b0001, 16'h5555, 0, -1, 1'b0, 1'b1);
      run_frame(4'b0100, 16'h0005, 1, -1, 1'b0, 1'b1);
      run_frame(4'b0010, 16'h0005, 0, 5, 1'b0, 1'b1);
      run_frame(4'b1000, FRAME_LEN'($urandom), 2, -1, 1'b1, 1'b1);
      for (int i = 0; i < 30; i++) begin
         ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, FRAME_LEN - 1)) : -1;
         run_frame(NREQ'($urandom_range(1, 2**NREQ - 1)), FRAME_LEN'($urandom),
                   int'($urandom_range(0, 2)), ab, ab < 0 && $urandom_range(0, 5) == 0, 1'b1);
      end
      @(negedge clk);
      bus.req = 4'b0010;
      wait_gnt();
      bus.bit_vld[1] = 1'b1;
      bus.bit_in[1] = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      bus.req = '0;
      bus.bit_vld = '0;
      @(negedge clk);
      rst_n = 1'b1;
      check_zero("rst_stream");
      ptr = 0;
      mon_en = 1'b0;
      run_frame(4'b0100, FRAME_LEN'($urandom), 0, -1, 1'b0, 1'b0);
      rst_n = 1'b0;
      bus.req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      check_zero("rst_report");
      hold_bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.res_vld !== 1'b0) hold_bad++;
      end
      check("no_result_after_reset", hold_bad, 0);
      mon_en = 1'b1;
      ptr = 0;
      run_frame('1, FRAME_LEN'($urandom), 2, -1, 1'b0, 1'b1);
      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("drain", exp_q.size(), 0);
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
      $fatal(1);
   end
endmodule
